aes_key_mem: RTL and testbench
==============================

// Module: aes_key_mem
// PURPOSE
//   Key expansion and round-key store for the AES encipher datapath. On init it
//   expands a 128- or 256-bit cipher key into 11 or 15 round keys, one per cycle.
//   It reaches its single SubWord through the shared external sbox port.
//   Keys are held in a 15x128-bit store. The round stage reads them combinationally by round number.
// PARAMETERS
//   AES128_ROUNDS  4'ha  last round index for 128-bit key (keys 0..10)
//   AES256_ROUNDS  4'he  last round index for 256-bit key (keys 0..14)
// PORTS
//   clk        in   1    clock, all state on rising edge
//   reset_n    in   1    asynchronous active-low reset
//   key        in   256  cipher key; AES-128 uses key[255:128]
//   keylen     in   1    0 = AES-128, 1 = AES-256; sampled with init
//   init       in   1    start expansion; honoured only while ready=1
//   round      in   4    round key index to read
//   round_key  out  128  key_mem[round]; 128'h0 when round=15
//   ready      out  1    1 = idle, store valid for last init
//   sboxw      out  32   word to external sbox: w3 of last generated key
//   new_sboxw  in   32   SubWord(sboxw), combinational from shared sbox
// BEHAVIOUR
//   - Reset (async): key_mem[0..14], prev_key0/prev_key1, round_ctr, key/keylen
//     latches all zero; rcon=8'h8d; FSM=IDLE; ready=1; round_key=0; sboxw=0.
//   - FSM: IDLE -(init)-> INIT -> GENERATE -(round_ctr==N)-> DONE -> IDLE.
//     N = AES128_ROUNDS or AES256_ROUNDS, from the keylen value latched at init.
//   - Edge T samples init=1 in IDLE. Key and keylen are latched, ready<=0, FSM->INIT.
//   - INIT (1 cycle): round_ctr<=0, rcon<=8'h8d.
//   - GENERATE: edges T+2..T+2+N write key_mem[round_ctr], then round_ctr++.
//   - DONE: ready<=1 at edge T+3+N, which is 13 cycles for AES-128 and 17 for AES-256.
//   - Every write also sets prev_key0<=prev_key1 and prev_key1<=new key.
//   - rot = {new_sboxw[23:0], new_sboxw[31:24]}. Round r generates key k as follows:
//       r=0: k = key[255:128].
//       AES-256 r=1: k = key[127:0].
//       AES-128 r>=1: t = rot ^ {rcon',24'h0}. Then w0=p1.w0^t, w1=w0^p1.w1,
//         w2=w1^p1.w2, w3=w2^p1.w3.
//       AES-256 even r>=2: t = rot ^ {rcon',24'h0}, chained as above on p0 words.
//       AES-256 odd r>=3: t = new_sboxw (no rot, no rcon), chained on p0 words.
//   - rcon' = xtime(rcon), written to rcon when used. 8'h8d gives 01 first, then
//     02,04,08,10,20,40,80,1b,36.
//   - xtime(x) = {x[6:0],1'b0} ^ (8'h1b & {8{x[7]}}).
//   - sboxw = prev_key1[31:0] at all times. No sbox request handshake; new_sboxw
//     must be valid in the same cycle.
//   - init while ready=0 is ignored. key/keylen changes after T do not affect the run.
//   - round is read asynchronously in any state. Entries are stale or partial
//     while ready=0. AES-128 leaves entries 11..14 untouched.
//   - reset_n low mid-expansion aborts at once with the full reset state above.
//     A new init is needed afterwards.
// CONFIGURATION
//   AES_KEY_MEM_CLEAR_EN defined:
//     - Adds input port clear (1 bit).
//     - clear=1 while ready=1 zeroes key_mem, prev_key0/1 and rcon(=8'h8d) in one edge.
//     - If init and clear are both asserted, clear wins and init is dropped.
//     - clear is ignored while ready=0.
//   AES_KEY_MEM_CLEAR_EN undefined:
//     - No clear port.
//     - The store persists until reset or overwrite.
// TESTING
//   1 reset -> ready=1, round_key=0 for every round 0..15, sboxw=0.
//   2 AES-128 key 2b7e1516_28aed2a6_abf71588_09cf4f3c:
//     ready low for 13 cycles. Then round 1 = a0fafe17_88542cb1_23a33939_2a6c7605
//     and round 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
//   3 AES-256 key 00010203..1e1f:
//     ready low for 17 cycles. Then round 0 = 00010203..0c0d0e0f
//     and round 14 = 24fc79cc_bf0979e9_371ac23c_6d68de36.
//   4 init pulsed again and key changed mid-run in test 2 -> results identical to test 2.
//   5 reset_n low at cycle 5 of test 3 -> immediate ready=1, all keys 0.
//     Re-init with AES-128 key 000102..0f -> round 10 = 13111d7f_e3944a17_f307a78b_4d2b30c5.
//   6 [CLEAR_EN] After test 2, clear=1 and init=1 on the same edge:
//     all round keys read 0, ready stays 1, no expansion starts.

Source files
------------

// File: rtl/aes_key_mem_if.sv
// Bus between the AES control/round logic and the key memory.
// Optional feature macro: AES_KEY_MEM_CLEAR_EN (adds the clear request).
interface aes_key_mem_if;
  logic [255:0] key;
  logic         keylen;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;
`ifdef AES_KEY_MEM_CLEAR_EN
  logic         clear;

  modport master (
    output key, keylen, init, round, new_sboxw, clear,
    input  round_key, ready, sboxw
  );
  modport slave (
    input  key, keylen, init, round, new_sboxw, clear,
    output round_key, ready, sboxw
  );
`else
  modport master (
    output key, keylen, init, round, new_sboxw,
    input  round_key, ready, sboxw
  );
  modport slave (
    input  key, keylen, init, round, new_sboxw,
    output round_key, ready, sboxw
  );
`endif
endinterface

// File: rtl/aes_key_mem.sv
// AES key expansion and 15 x 128-bit round-key store.
// Generates one round key per cycle after init; SubWord goes through the
// shared external sbox (sboxw out, new_sboxw back in the same cycle).
// Optional feature macro: AES_KEY_MEM_CLEAR_EN adds a store clear request.
module aes_key_mem #(
  parameter logic [3:0] AES128_ROUNDS = 4'ha,
  parameter logic [3:0] AES256_ROUNDS = 4'he
) (
  input  logic         clk,
  input  logic         reset_n,
  aes_key_mem_if.slave kif
);

  localparam logic [7:0] RCON_INIT = 8'h8d;   // xtime(8'h8d) == 8'h01

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_GEN,
    ST_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [255:0]       key_q, key_d;
  logic               keylen_q, keylen_d;
  logic [3:0]         round_ctr_q, round_ctr_d;
  logic [7:0]         rcon_q, rcon_d;
  logic [127:0]       prev_key0_q, prev_key0_d;
  logic [127:0]       prev_key1_q, prev_key1_d;
  logic               ready_q, ready_d;
  logic [14:0][127:0] key_mem_q;

  logic               mem_we;
  logic               mem_clr;
  logic               clear_req;
  logic [3:0]         last_round;
  logic               use_rcon;
  logic [7:0]         rcon_nxt;
  logic [31:0]        rot_w;
  logic [31:0]        tmp_w;
  logic [31:0]        w0, w1, w2, w3;
  logic [127:0]       base_key;
  logic [127:0]       new_key;
  logic [127:0]       rd_key;

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (8'h1b & {8{x[7]}});
  endfunction

`ifdef AES_KEY_MEM_CLEAR_EN
  assign clear_req = kif.clear;
`else
  assign clear_req = 1'b0;
`endif

  assign last_round = keylen_q ? AES256_ROUNDS : AES128_ROUNDS;

  // Next round key from the previous one or two keys and the sbox result.
  always_comb begin
    rcon_nxt = xtime(rcon_q);
    rot_w    = {kif.new_sboxw[23:0], kif.new_sboxw[31:24]};
    // AES-128 uses rcon on every derived key; AES-256 only on even ones,
    // odd AES-256 keys take a plain SubWord of the previous w3.
    if (keylen_q)
      use_rcon = !round_ctr_q[0] && (round_ctr_q != 4'd0);
    else
      use_rcon = (round_ctr_q != 4'd0);
    tmp_w    = use_rcon ? (rot_w ^ {rcon_nxt, 24'h0}) : kif.new_sboxw;
    // AES-128 chains on the key just written, AES-256 on the one before it.
    base_key = keylen_q ? prev_key0_q : prev_key1_q;
    w0       = base_key[127:96] ^ tmp_w;
    w1       = w0 ^ base_key[95:64];
    w2       = w1 ^ base_key[63:32];
    w3       = w2 ^ base_key[31:0];
    if (round_ctr_q == 4'd0)
      new_key = key_q[255:128];
    else if (keylen_q && (round_ctr_q == 4'd1))
      new_key = key_q[127:0];
    else
      new_key = {w0, w1, w2, w3};
  end

  // FSM next state plus next values for the expansion registers.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    keylen_d    = keylen_q;
    round_ctr_d = round_ctr_q;
    rcon_d      = rcon_q;
    prev_key0_d = prev_key0_q;
    prev_key1_d = prev_key1_q;
    ready_d     = ready_q;
    mem_we      = 1'b0;
    mem_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // clear has priority; a simultaneous init is dropped.
        if (clear_req) begin
          mem_clr     = 1'b1;
          prev_key0_d = '0;
          prev_key1_d = '0;
          rcon_d      = RCON_INIT;
        end else if (kif.init) begin
          key_d    = kif.key;
          keylen_d = kif.keylen;
          ready_d  = 1'b0;
          state_d  = ST_INIT;
        end
      end
      ST_INIT: begin
        round_ctr_d = 4'd0;
        rcon_d      = RCON_INIT;
        state_d     = ST_GEN;
      end
      ST_GEN: begin
        mem_we      = 1'b1;
        prev_key0_d = prev_key1_q;
        prev_key1_d = new_key;
        if (use_rcon)
          rcon_d = rcon_nxt;
        round_ctr_d = round_ctr_q + 4'd1;
        if (round_ctr_q == last_round)
          state_d = ST_DONE;
      end
      ST_DONE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and expansion registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      keylen_q    <= 1'b0;
      round_ctr_q <= 4'd0;
      rcon_q      <= RCON_INIT;
      prev_key0_q <= '0;
      prev_key1_q <= '0;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      keylen_q    <= keylen_d;
      round_ctr_q <= round_ctr_d;
      rcon_q      <= rcon_d;
      prev_key0_q <= prev_key0_d;
      prev_key1_q <= prev_key1_d;
      ready_q     <= ready_d;
    end
  end

  // Round-key store: one entry written per generate cycle, bulk clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_mem_q <= '0;
    end else if (mem_clr) begin
      key_mem_q <= '0;
    end else if (mem_we) begin
      for (int i = 0; i < 15; i++)
        if (round_ctr_q == 4'(i))
          key_mem_q[i] <= new_key;
    end
  end

  // Asynchronous read; index 15 has no entry and reads as zero.
  always_comb begin
    rd_key = '0;
    for (int i = 0; i < 15; i++)
      if (kif.round == 4'(i))
        rd_key = key_mem_q[i];
  end

  assign kif.round_key = rd_key;
  assign kif.ready     = ready_q;
  assign kif.sboxw     = prev_key1_q[31:0];

endmodule

// File: tb/tb_aes_key_mem.sv
// Scoreboard bench for aes_key_mem: FIPS-197 word-based reference expansion,
// reads queued by the stimulus and checked by an independent monitor.
module tb_aes_key_mem;

  logic clk;
  logic reset_n;

  aes_key_mem_if bus();

  aes_key_mem dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kif    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference sbox (GF(2^8) inverse + affine) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    logic [7:0] s;
    logic [7:0] b;
    int e;
    r = 8'h01;
    p = x;
    e = 254;
    while (e != 0) begin
      if (e % 2 == 1) r = gmul(r, p);
      p = gmul(p, p);
      e = e / 2;
    end
    s = r;
    b = r;
    for (int k = 0; k < 4; k++) begin
      b = {b[6:0], b[7]};
      s = s ^ b;
    end
    return s ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // The shared sbox the key memory borrows.
  assign bus.new_sboxw = subword(bus.sboxw);

  // ---------------- reference store model ----------------
  logic [127:0] exp_mem [16];
  logic [31:0]  exp_sboxw;

  task automatic model_clear();
    for (int r = 0; r < 16; r++) exp_mem[r] = '0;
    exp_sboxw = '0;
  endtask

  task automatic model_expand(input logic [255:0] k, input logic kl);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk, nr, total;
    nk    = kl ? 8 : 4;
    nr    = kl ? 14 : 10;
    total = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++)
      exp_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    exp_sboxw = w[total-1];
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] rk;
    logic [31:0]  sw;
  } rd_t;

  rd_t sb_q [$];
  int  lat_q [$];
  int  checks;
  int  errors;
  int  lat_cnt;

  task automatic chk(input string nm, input int idx, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Read monitor: one queued read per cycle, checked mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        rd_t it;
        it = sb_q.pop_front();
        chk("round_key", int'(it.rnd), bus.round_key, it.rk);
        chk("sboxw", int'(it.rnd), {96'h0, bus.sboxw}, {96'h0, it.sw});
        chk("ready", int'(it.rnd), {127'h0, bus.ready}, 128'h1);
      end
    end
  end

  // Busy-time monitor: measures each ready-low window.
  initial begin
    lat_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.ready !== 1'b1) begin
        lat_cnt++;
      end else begin
        if (lat_cnt > 0) begin
          if (lat_q.size() == 0)
            chk("unexpected_busy", lat_cnt, 128'(lat_cnt), 128'h0);
          else
            chk("busy_cycles", lat_q[0], 128'(lat_cnt), 128'(lat_q.pop_front()));
        end
        lat_cnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_read(input logic [3:0] r, input logic [127:0] rk);
    rd_t it;
    bus.round = r;
    it.rnd = r;
    it.rk  = rk;
    it.sw  = exp_sboxw;
    sb_q.push_back(it);
    step();
  endtask

  task automatic read_all();
    for (int r = 0; r < 16; r++) push_read(4'(r), exp_mem[r]);
  endtask

  task automatic start_init(input logic [255:0] k, input logic kl);
    bus.key    = k;
    bus.keylen = kl;
    bus.init   = 1'b1;
    step();
    bus.init = 1'b0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    if (bus.ready !== 1'b1) chk("ready_timeout", n, 128'h0, 128'h1);
  endtask

  task automatic run(input logic [255:0] k, input logic kl, input bit disturb);
    start_init(k, kl);
    model_expand(k, kl);
    lat_q.push_back(kl ? 17 : 13);
    if (disturb) begin
      for (int i = 0; i < 10; i++) begin
        bus.init   = 1'($urandom_range(0, 1));
        bus.keylen = 1'($urandom_range(0, 1));
        bus.key    = {$urandom(), $urandom(), $urandom(), $urandom(),
                      $urandom(), $urandom(), $urandom(), $urandom()};
        step();
      end
      bus.init = 1'b0;
    end
    wait_ready();
  endtask

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY128B = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};

  initial begin
    logic [255:0] rk;
    logic         kl;
    checks     = 0;
    errors     = 0;
    bus.key    = '0;
    bus.keylen = 1'b0;
    bus.init   = 1'b0;
    bus.round  = 4'd0;
`ifdef AES_KEY_MEM_CLEAR_EN
    bus.clear  = 1'b0;
`endif
    model_clear();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();

    // reset state
    read_all();

    // AES-128 known answer
    run(KEY128, 1'b0, 1'b0);
    read_all();
    push_read(4'd1,  128'ha0fafe1788542cb123a339392a6c7605);
    push_read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // same key with init pulses and key/keylen churn during the run
    run(KEY128, 1'b0, 1'b1);
    read_all();
    push_read(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

`ifdef AES_KEY_MEM_CLEAR_EN
    // clear beats a simultaneous init
    bus.key    = KEY256;
    bus.keylen = 1'b1;
    bus.init   = 1'b1;
    bus.clear  = 1'b1;
    step();
    bus.init   = 1'b0;
    bus.clear  = 1'b0;
    model_clear();
    read_all();
`endif

    // AES-256 known answer
    run(KEY256, 1'b1, 1'b0);
    read_all();
    push_read(4'd0,  128'h000102030405060708090a0b0c0d0e0f);
    push_read(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // AES-128 after AES-256: entries 11..14 keep the AES-256 keys
    run(KEY128B, 1'b0, 1'b0);
    read_all();

    // randomized runs with random reads
    for (int n = 0; n < 4; n++) begin
      rk = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      kl = 1'($urandom_range(0, 1));
      run(rk, kl, 1'($urandom_range(0, 1)));
      for (int j = 0; j < 6; j++) begin
        rd_t tmp;
        tmp.rnd = 4'($urandom_range(0, 15));
        push_read(tmp.rnd, exp_mem[tmp.rnd]);
      end
    end

    // abort an AES-256 run with reset, then re-init
    start_init(KEY256, 1'b1);
    lat_q.push_back(4);
    repeat (4) @(posedge clk);
    #1;
    reset_n = 1'b0;
    model_clear();
    push_read(4'd14, '0);
    reset_n = 1'b1;
    read_all();
    run(KEY128B, 1'b0, 1'b0);
    push_read(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    read_all();

    repeat (3) step();
    chk("sb_drain", 0, 128'(sb_q.size()), 128'h0);
    chk("lat_drain", 0, 128'(lat_q.size()), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
